alu_mdu_unit: RTL
=================

# alu_mdu_unit

Parametrised multiply/divide unit for the multi-cycle MIPS datapath, sitting beside the ALU and sharing the ALU controller's `ctrl`/`Funct` decode inputs. It executes `mult`, `multu`, `div`, `divu`, `mthi`, `mtlo`, `mfhi` and `mflo` using an iterative shift-add / restoring-divide engine. Results are held in architectural HI/LO registers. The sequence controller stalls on `Busy` and resumes on `Done`.

## Interface
- `WIDTH`, 32: operand, HI and LO width; must be ≥ 4.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width (derived; do not override).

- `CLK`  in  1  system clock, rising edge
- `RST`  in  1  reset; synchronous, active-high
- `Start`  in  1  request; sampled only when `Busy`=0
- `ctrl`  in  3  ALU_OP from sequence controller; the unit acts only when `ctrl`=3'b010 (R-type)
- `Funct`  in  6  instruction bits [5:0]
- `A`  in  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo source)
- `B`  in  WIDTH  rt operand (divisor / multiplier)
- `Busy`  out  1  engine iterating; new `Start` ignored
- `Done`  out  1  one-cycle pulse: HI/LO updated on the preceding edge
- `HI`  out  WIDTH  HI register
- `LO`  out  WIDTH  LO register
- `Result`  out  WIDTH  combinational: HI if `Funct`=010000 (mfhi), LO if 010010 (mflo), else 0; valid only when `ctrl`=010
- `Is_MDU`  out  1  combinational: `ctrl`=010 and `Funct` ∈ {010000, 010001, 010010, 010011, 011000, 011001, 011010, 011011}

## Operation
- **Accepted request:** `Start`=1, `Busy`=0, `ctrl`=010, and `Funct` is one of 010001 (mthi), 010011 (mtlo), 011000 (mult), 011001 (multu), 011010 (div) or 011011 (divu). Any other combination is a no-op.
- **States:**
  - IDLE to MUL on mult/multu.
  - IDLE to DIV on div/divu with B≠0.
  - IDLE to FIX on div/divu with B=0.
  - MUL or DIV to FIX when the counter reaches WIDTH.
  - FIX to IDLE always.
  - mthi/mtlo stay in IDLE.
- **At accept:**
  - Latch op and signedness.
  - Signed ops latch |A| and |B|, plus sign flags sA and sB.
  - Unsigned ops latch A and B raw.
  - Clear the counter and the accumulator.
- **MUL:** one shift-add step per cycle over the 2·WIDTH product of the magnitudes.
- **DIV:** one restoring step per cycle producing the quotient bit and partial remainder.
- **FIX (signed correction):**
  - Product is negated if sA^sB.
  - Quotient is negated if sA^sB.
  - Remainder takes the sign of A.
  - Writes HI ← upper/remainder and LO ← lower/quotient.
- **Divide by zero:** LO ← all-ones, HI ← A (raw, unsigned view), for both div and divu.
- **Overflow:** signed −2^(WIDTH−1) / −1 gives LO = 1000…0 and HI = 0; no trap.
- **mthi/mtlo:** HI ← A (mthi) or LO ← A (mtlo) on the accepting edge. The other register is unchanged.
- **Width rule:** the magnitude of −2^(WIDTH−1) is computed as unsigned WIDTH-bit 2^(WIDTH−1). No extra bit is needed; internal accumulators are 2·WIDTH wide.

## Timing
- **Reset:** on a `RST` edge, the state goes to IDLE and `Busy`, `Done`, `HI`, `LO` and the counter are all set to 0. This applies mid-operation too: the in-flight result is discarded and HI/LO are cleared.
- **mult/multu/div/divu (B≠0), accepted at edge k:**
  - `Busy`=1 from k to k+WIDTH+1.
  - Iterations run on edges k+1 … k+WIDTH.
  - FIX writes HI/LO at edge k+WIDTH+1.
  - `Busy` falls and `Done`=1 for the cycle after k+WIDTH+1.
  - Latency is WIDTH+1 cycles.
- **div/divu with B=0:** HI/LO are written at edge k+1 and `Done` pulses in the following cycle.
- **mthi/mtlo:** the write happens at edge k, `Done` pulses in the following cycle, and `Busy` stays 0.
- **Back-to-back:** a new `Start` may be accepted in the same cycle `Done` is high, because `Busy` is already 0.
- **Start while `Busy`=1:** ignored with no side effects.
- **`Result` read in the `Done` cycle:** returns the new HI/LO value.

## Test plan
- **Signed multiply:** WIDTH=32, mult A=0xFFFFFFFE, B=3 → after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA, `Done` 1 cycle.
- **Unsigned multiply:** multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- **Signed divide:**
  - div A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero:** divu A=100, B=0 → `Done` 2 cycles after `Start`, LO=0xFFFFFFFF, HI=100.
- **Start while busy:** mtlo A=0x1234 issued during a busy mult → ignored, and the final LO equals the product. Then mtlo when idle → LO=0x1234, HI unchanged, `Result` with mflo = 0x1234.
- **Reset mid-operation:** `RST` asserted at iteration 10 of mult → the next cycle shows `Busy`=0, HI=LO=0, and no `Done` pulse.

Source files
------------

// File: rtl/alu_mdu_unit.sv
// alu_mdu_unit: iterative multiply/divide unit with architectural HI/LO.
// Multiplies by shift-add and divides by restoring division over operand
// magnitudes, then applies the sign correction in a final FIX cycle.
module alu_mdu_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [2:0]       ctrl,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] Result,
    output logic             Is_MDU
);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t state;
    state_t state_next;

    logic               op_div;
    logic               s_a;
    logic               s_b;
    logic               div_zero;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    logic               is_rtype;
    logic               f_mul;
    logic               f_div;
    logic               f_move;
    logic               f_signed;
    logic               accept;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               last_iter;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_r;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   raw_a;

    assign is_rtype = (ctrl == 3'b010);
    assign f_mul    = (Funct == F_MULT) || (Funct == F_MULTU);
    assign f_div    = (Funct == F_DIV)  || (Funct == F_DIVU);
    assign f_move   = (Funct == F_MTHI) || (Funct == F_MTLO);
    assign f_signed = (Funct == F_MULT) || (Funct == F_DIV);
    assign accept   = Start && (state == IDLE) && is_rtype && (f_mul || f_div || f_move);

    // The magnitude of the most negative value wraps to 2^(WIDTH-1), which is
    // exactly right when the register is read as unsigned.
    assign a_neg = f_signed && A[WIDTH-1];
    assign b_neg = f_signed && B[WIDTH-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // Shift-add step: the multiplier is consumed from mag_b LSB first while the
    // partial product shifts right through acc.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mag_b[0] ? {1'b0, mag_a} : '0);

    // Restoring step: remainder lives in acc low half, dividend bits shift out
    // of mag_a while quotient bits shift in behind them.
    assign div_r    = {acc[WIDTH-1:0], mag_a[WIDTH-1]};
    assign div_diff = {1'b0, div_r} - {2'b00, mag_b};
    assign div_ok   = ~div_diff[WIDTH+1];
    assign div_rem  = div_ok ? div_diff[WIDTH-1:0] : div_r[WIDTH-1:0];

    // Sign correction; undoing the magnitude on mag_a recovers the raw A.
    assign prod_fix = (s_a ^ s_b) ? -acc : acc;
    assign quo_fix  = (s_a ^ s_b) ? -mag_a : mag_a;
    assign rem_fix  = s_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign raw_a    = s_a ? -mag_a : mag_a;

    assign Busy = (state != IDLE);

    // Decode-side outputs used by the controller and the register write-back.
    always_comb begin
        Result = '0;
        Is_MDU = 1'b0;
        if (Funct == F_MFHI) begin
            Result = HI;
        end else if (Funct == F_MFLO) begin
            Result = LO;
        end
        if (is_rtype && (f_mul || f_div || f_move || Funct == F_MFHI || Funct == F_MFLO)) begin
            Is_MDU = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection: divide by zero skips straight to FIX.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && f_mul) begin
                    state_next = MUL;
                end else if (accept && f_div) begin
                    state_next = (B == '0) ? FIX : DIV;
                end
            end
            MUL, DIV: begin
                if (last_iter) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand latch, per-cycle iteration and the HI/LO write-back.
    always_ff @(posedge CLK) begin
        if (RST) begin
            HI       <= '0;
            LO       <= '0;
            Done     <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            op_div   <= 1'b0;
            s_a      <= 1'b0;
            s_b      <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && Funct == F_MTHI) begin
                        HI   <= A;
                        Done <= 1'b1;
                    end else if (accept && Funct == F_MTLO) begin
                        LO   <= A;
                        Done <= 1'b1;
                    end else if (accept) begin
                        op_div   <= f_div;
                        s_a      <= a_neg;
                        s_b      <= b_neg;
                        div_zero <= (B == '0);
                        mag_a    <= a_mag;
                        mag_b    <= b_mag;
                        cnt      <= '0;
                        acc      <= '0;
                    end
                end
                MUL: begin
                    acc   <= {mul_sum, acc[WIDTH-1:1]};
                    mag_b <= mag_b >> 1;
                    cnt   <= cnt + 1'b1;
                end
                DIV: begin
                    acc[WIDTH-1:0] <= div_rem;
                    mag_a          <= {mag_a[WIDTH-2:0], div_ok};
                    cnt            <= cnt + 1'b1;
                end
                FIX: begin
                    Done <= 1'b1;
                    if (op_div && div_zero) begin
                        HI <= raw_a;
                        LO <= '1;
                    end else if (op_div) begin
                        HI <= rem_fix;
                        LO <= quo_fix;
                    end else begin
                        HI <= prod_fix[2*WIDTH-1:WIDTH];
                        LO <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
